// File: rtl/gba_cart_responder_if.sv
// Cart bus and external ROM-fetch port of the GBA cartridge responder.
// The responder connects through the slave modport; the core/memory side uses master.
interface gba_cart_responder_if #(
  parameter int unsigned ROM_AW = 23
);
  logic [31:0]       cart_addr;
  logic              cart_rd;
  logic              cart_wr;
  logic [31:0]       cart_do;
  logic [31:0]       cart_di;
  logic              cpu_pause;
  logic              rom_req;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_ack;
  logic [31:0]       rom_data;
  logic              overrun;

  modport slave (
    input  cart_addr, cart_rd, cart_wr, cart_do, rom_ack, rom_data,
    output cart_di, cpu_pause, rom_req, rom_addr, overrun
  );

  modport master (
    output cart_addr, cart_rd, cart_wr, cart_do, rom_ack, rom_data,
    input  cart_di, cpu_pause, rom_req, rom_addr, overrun
  );
endinterface

// File: rtl/gba_cart_responder.sv
// Cartridge responder: ROM reads through a one-word hit buffer backed by external
// variable-latency memory, backup SRAM in a local byte-wide BRAM.
module gba_cart_responder #(
  parameter int unsigned ROM_AW    = 23,
  parameter int unsigned BACKUP_AW = 15
) (
  input logic                  clock,
  input logic                  reset,
  gba_cart_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ROM_WAIT,
    SRAM_RD
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         cart_di_q, cart_di_d;
  logic                cpu_pause_q, cpu_pause_d;
  logic                rom_req_q, rom_req_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                overrun_q, overrun_d;
  logic                buf_valid_q, buf_valid_d;
  logic [ROM_AW-1:0]   buf_tag_q, buf_tag_d;
  logic [31:0]         buf_data_q, buf_data_d;

  logic [7:0]          sram_mem [2**BACKUP_AW];
  logic [7:0]          sram_rdata_q;
  logic                sram_rd_en;

  logic [7:0]          region;
  logic                is_rom, is_sram;
  logic [ROM_AW-1:0]   word_addr;
  logic [BACKUP_AW-1:0] byte_addr;
  logic                buf_hit;
  logic                rd_accept;
  logic                unused_do_bits;

  assign region    = bus.cart_addr[31:24];
  assign is_rom    = (region >= 8'h08) && (region <= 8'h0D);
  assign is_sram   = (region == 8'h0E) || (region == 8'h0F);
  assign word_addr = bus.cart_addr[ROM_AW+1:2];
  assign byte_addr = bus.cart_addr[BACKUP_AW-1:0];
  assign buf_hit   = buf_valid_q && (buf_tag_q == word_addr);
  // A read colliding with a write, or arriving while busy, is dropped.
  assign rd_accept = bus.cart_rd && !bus.cart_wr && (state_q == IDLE);
  assign unused_do_bits = ^bus.cart_do[31:8];

  always_comb begin
    state_d     = state_q;
    cart_di_d   = cart_di_q;
    cpu_pause_d = cpu_pause_q;
    rom_req_d   = rom_req_q;
    rom_addr_d  = rom_addr_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    sram_rd_en  = 1'b0;
    overrun_d   = overrun_q | (bus.cart_rd & ~rd_accept);

    case (state_q)
      IDLE: begin
        if (rd_accept) begin
          if (is_rom) begin
            if (buf_hit) begin
              cart_di_d = buf_data_q;
            end else begin
              rom_req_d   = 1'b1;
              rom_addr_d  = word_addr;
              cpu_pause_d = 1'b1;
              state_d     = ROM_WAIT;
            end
          end else if (is_sram) begin
            sram_rd_en  = 1'b1;
            cpu_pause_d = 1'b1;
            state_d     = SRAM_RD;
          end else begin
            cart_di_d = '0;
          end
        end
      end
      ROM_WAIT: begin
        if (bus.rom_ack) begin
          cart_di_d   = bus.rom_data;
          buf_valid_d = 1'b1;
          buf_tag_d   = rom_addr_q;
          buf_data_d  = bus.rom_data;
          rom_req_d   = 1'b0;
          cpu_pause_d = 1'b0;
          state_d     = IDLE;
        end
      end
      SRAM_RD: begin
        cart_di_d   = {4{sram_rdata_q}};
        cpu_pause_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cart_di_q   <= '0;
      cpu_pause_q <= 1'b0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      overrun_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cart_di_q   <= cart_di_d;
      cpu_pause_q <= cpu_pause_d;
      rom_req_q   <= rom_req_d;
      rom_addr_q  <= rom_addr_d;
      overrun_q   <= overrun_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // Backup RAM keeps its contents across reset; writes are accepted in any state.
  always_ff @(posedge clock) begin
    if (bus.cart_wr && is_sram) begin
      sram_mem[byte_addr] <= bus.cart_do[7:0];
    end
    if (sram_rd_en) begin
      sram_rdata_q <= sram_mem[byte_addr];
    end
  end

  assign bus.cart_di   = cart_di_q;
  assign bus.cpu_pause = cpu_pause_q;
  assign bus.rom_req   = rom_req_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_gba_cart_responder.sv
// Directed bench for gba_cart_responder: ROM miss/hit, SRAM access, overrun, reset mid-fetch.
module tb_gba_cart_responder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  gba_cart_responder_if #(.ROM_AW(23)) bus ();

  gba_cart_responder #(.ROM_AW(23), .BACKUP_AW(15)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.cart_di !== 32'h0) begin errors++; $display("FAIL reset_cart_di got %h exp %h", bus.cart_di, 32'h0); end
    checks++; if (bus.cpu_pause !== 1'b0) begin errors++; $display("FAIL reset_pause got %b exp 0", bus.cpu_pause); end
    checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL reset_rom_req got %b exp 0", bus.rom_req); end
    checks++; if (bus.rom_addr !== 23'h0) begin errors++; $display("FAIL reset_rom_addr got %h exp 0", bus.rom_addr); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
  endtask

  task automatic test_rom_miss;
    bus.cart_addr = 32'h0800_0004; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL miss_req_%0d got %b exp 1", i, bus.rom_req); end
      checks++; if (bus.rom_addr !== 23'h1) begin errors++; $display("FAIL miss_addr_%0d got %h exp 1", i, bus.rom_addr); end
      checks++; if (bus.cpu_pause !== 1'b1) begin errors++; $display("FAIL miss_pause_%0d got %b exp 1", i, bus.cpu_pause); end
      if (i < 2) tick();
    end
    bus.rom_ack = 1'b1; bus.rom_data = 32'hDEAD_BEEF;
    tick();
    bus.rom_ack = 1'b0; bus.rom_data = 32'h0;
    checks++; if (bus.cart_di !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_data got %h exp %h", bus.cart_di, 32'hDEAD_BEEF); end
    checks++; if (bus.cpu_pause !== 1'b0) begin errors++; $display("FAIL miss_pause_end got %b exp 0", bus.cpu_pause); end
    checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL miss_req_end got %b exp 0", bus.rom_req); end
  endtask

  task automatic test_rom_hit;
    logic [31:0] hit_addrs [2];
    hit_addrs[0] = 32'h0800_0004;
    hit_addrs[1] = 32'h0A00_0004;
    for (int i = 0; i < 2; i++) begin
      bus.cart_addr = 32'h0300_0000; bus.cart_rd = 1'b1;
      tick();
      checks++; if (bus.cart_di !== 32'h0) begin errors++; $display("FAIL hit_clear_%0d got %h exp 0", i, bus.cart_di); end
      bus.cart_addr = hit_addrs[i];
      tick();
      bus.cart_rd = 1'b0;
      checks++; if (bus.cart_di !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_data_%0d got %h exp %h", i, bus.cart_di, 32'hDEAD_BEEF); end
      checks++; if (bus.cpu_pause !== 1'b0) begin errors++; $display("FAIL hit_pause_%0d got %b exp 0", i, bus.cpu_pause); end
      checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL hit_req_%0d got %b exp 0", i, bus.rom_req); end
      tick();
      checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL hit_req_after_%0d got %b exp 0", i, bus.rom_req); end
    end
  endtask

  task automatic test_sram;
    bus.cart_addr = 32'h0E00_0010; bus.cart_do = 32'h0000_00A5; bus.cart_wr = 1'b1;
    tick();
    bus.cart_wr = 1'b0;
    checks++; if (bus.cpu_pause !== 1'b0) begin errors++; $display("FAIL sram_wr_pause got %b exp 0", bus.cpu_pause); end
    bus.cart_addr = 32'h0E00_8010; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    checks++; if (bus.cpu_pause !== 1'b1) begin errors++; $display("FAIL sram_rd_pause got %b exp 1", bus.cpu_pause); end
    checks++; if (bus.cart_di !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sram_rd_early got %h exp %h", bus.cart_di, 32'hDEAD_BEEF); end
    tick();
    checks++; if (bus.cart_di !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sram_rd_data got %h exp %h", bus.cart_di, 32'hA5A5_A5A5); end
    checks++; if (bus.cpu_pause !== 1'b0) begin errors++; $display("FAIL sram_rd_pause_end got %b exp 0", bus.cpu_pause); end
  endtask

  task automatic test_overrun;
    bus.cart_addr = 32'h0800_0100; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL ovr_req got %b exp 1", bus.rom_req); end
    checks++; if (bus.rom_addr !== 23'h40) begin errors++; $display("FAIL ovr_addr got %h exp 40", bus.rom_addr); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", bus.overrun); end
    bus.cart_addr = 32'h0800_0200; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", bus.overrun); end
    checks++; if (bus.rom_addr !== 23'h40) begin errors++; $display("FAIL ovr_addr_hold got %h exp 40", bus.rom_addr); end
    bus.rom_ack = 1'b1; bus.rom_data = 32'hCAFE_F00D;
    tick();
    bus.rom_ack = 1'b0;
    checks++; if (bus.cart_di !== 32'hCAFE_F00D) begin errors++; $display("FAIL ovr_data got %h exp %h", bus.cart_di, 32'hCAFE_F00D); end
    tick();
    tick();
    checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL ovr_no_second_req got %b exp 0", bus.rom_req); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", bus.overrun); end
  endtask

  task automatic test_reset_mid_fetch;
    bus.cart_addr = 32'h0800_0300; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL rmf_req got %b exp 1", bus.rom_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL rmf_req_drop got %b exp 0", bus.rom_req); end
    checks++; if (bus.cpu_pause !== 1'b0) begin errors++; $display("FAIL rmf_pause got %b exp 0", bus.cpu_pause); end
    bus.rom_ack = 1'b1; bus.rom_data = 32'h1234_5678;
    tick();
    bus.rom_ack = 1'b0;
    checks++; if (bus.cart_di !== 32'h0) begin errors++; $display("FAIL rmf_late_ack got %h exp 0", bus.cart_di); end
    bus.cart_addr = 32'h0800_0100; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL rmf_buf_invalid got %b exp 1", bus.rom_req); end
    bus.rom_ack = 1'b1; bus.rom_data = 32'h0BAD_F00D;
    tick();
    bus.rom_ack = 1'b0;
    checks++; if (bus.cart_di !== 32'h0BAD_F00D) begin errors++; $display("FAIL rmf_refetch got %h exp %h", bus.cart_di, 32'h0BAD_F00D); end
    bus.cart_addr = 32'h0800_0300; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL rmf_same_miss got %b exp 1", bus.rom_req); end
    checks++; if (bus.rom_addr !== 23'hC0) begin errors++; $display("FAIL rmf_same_addr got %h exp c0", bus.rom_addr); end
    bus.rom_ack = 1'b1; bus.rom_data = 32'h1122_3344;
    tick();
    bus.rom_ack = 1'b0;
    checks++; if (bus.cart_di !== 32'h1122_3344) begin errors++; $display("FAIL rmf_same_data got %h exp %h", bus.cart_di, 32'h1122_3344); end
  endtask

  task automatic test_ignored;
    bus.cart_addr = 32'h0E00_0000; bus.cart_do = 32'h0000_003C; bus.cart_wr = 1'b1;
    tick();
    bus.cart_addr = 32'h0800_0000; bus.cart_do = 32'hFFFF_FFFF;
    tick();
    bus.cart_wr = 1'b0;
    checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL ign_wr_req got %b exp 0", bus.rom_req); end
    checks++; if (bus.cpu_pause !== 1'b0) begin errors++; $display("FAIL ign_wr_pause got %b exp 0", bus.cpu_pause); end
    bus.cart_addr = 32'h0300_0000; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    checks++; if (bus.cart_di !== 32'h0) begin errors++; $display("FAIL ign_unmapped got %h exp 0", bus.cart_di); end
    checks++; if (bus.cpu_pause !== 1'b0) begin errors++; $display("FAIL ign_unmapped_pause got %b exp 0", bus.cpu_pause); end
    checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL ign_unmapped_req got %b exp 0", bus.rom_req); end
    bus.cart_addr = 32'h0E00_0000; bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    tick();
    checks++; if (bus.cart_di !== 32'h3C3C_3C3C) begin errors++; $display("FAIL ign_bram_intact got %h exp %h", bus.cart_di, 32'h3C3C_3C3C); end
  endtask

  task automatic test_back_to_back;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.cart_addr = 32'h0E00_0020; bus.cart_do = 32'h0000_005A;
    bus.cart_wr = 1'b1; bus.cart_rd = 1'b1;
    tick();
    bus.cart_wr = 1'b0; bus.cart_rd = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b exp 1", bus.overrun); end
    checks++; if (bus.cpu_pause !== 1'b0) begin errors++; $display("FAIL b2b_pause got %b exp 0", bus.cpu_pause); end
    tick();
    checks++; if (bus.cart_di !== 32'h0) begin errors++; $display("FAIL b2b_no_read got %h exp 0", bus.cart_di); end
    bus.cart_rd = 1'b1;
    tick();
    bus.cart_rd = 1'b0;
    tick();
    checks++; if (bus.cart_di !== 32'h5A5A_5A5A) begin errors++; $display("FAIL b2b_write_done got %h exp %h", bus.cart_di, 32'h5A5A_5A5A); end
    bus.rom_ack = 1'b1; bus.rom_data = 32'h9999_9999;
    tick();
    bus.rom_ack = 1'b0;
    checks++; if (bus.cart_di !== 32'h5A5A_5A5A) begin errors++; $display("FAIL b2b_idle_ack got %h exp %h", bus.cart_di, 32'h5A5A_5A5A); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cart_addr = '0;
    bus.cart_rd   = 1'b0;
    bus.cart_wr   = 1'b0;
    bus.cart_do   = '0;
    bus.rom_ack   = 1'b0;
    bus.rom_data  = '0;
    test_reset();
    test_rom_miss();
    test_rom_hit();
    test_sram();
    test_overrun();
    test_reset_mid_fetch();
    test_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
